// File: rtl/mem_writeback_if.sv
// Data-memory bus between the M stage (master) and data memory (slave).
interface mem_writeback_if #(
    parameter int DMEM_AW = 14
);
    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [3:0]         dmem_be;
    logic               dmem_gnt;
    logic               dmem_rvalid;
    logic [31:0]        dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_writeback.sv
// RV32I memory/writeback back end: M register with dmem handshake FSM,
// load alignment/extension, W register and forwarding/stall outputs.
module mem_writeback #(
    parameter int DMEM_AW = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_result,
    input  logic [31:0]           ex_store_data,
    input  logic [2:0]            ex_funct3,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_reg_we,
    input  logic                  ex_mem_rr,
    input  logic                  ex_mem_we,
    output logic                  ex_stall,
    mem_writeback_if.master       dmem,
    output logic [31:0]           prev_value,
    output logic [4:0]            prev_rd,
    output logic                  prev_reg_we,
    output logic                  prev_mem_rr,
    output logic [31:0]           wb_value,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_we,
    output logic                  wb_mem_rr,
    output logic                  misaligned
);
    typedef enum logic [1:0] {S_IDLE, S_ALU, S_REQ, S_WAIT} state_t;

    state_t      r_state;
    logic [31:0] r_m_result, r_m_sdata;
    logic [2:0]  r_m_f3;
    logic [4:0]  r_m_rd;
    logic        r_m_reg_we, r_m_rr, r_m_st, r_m_mis;
    logic [31:0] r_wb_value;
    logic [4:0]  r_wb_rd;
    logic        r_wb_we, r_wb_rr;

    logic        w_m_valid, w_complete, w_capture, w_ex_mem, w_ex_mis, w_req;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shift, w_ld;

    assign w_m_valid  = (r_state != S_IDLE);
    assign w_complete = (r_state == S_ALU)
                      | ((r_state == S_REQ) & dmem.dmem_gnt & r_m_st)
                      | ((r_state == S_WAIT) & dmem.dmem_rvalid);
    assign ex_stall   = w_m_valid & ~w_complete;
    assign w_capture  = ex_valid & ~ex_stall;
    assign w_ex_mem   = ex_mem_rr | ex_mem_we;

    // Size comes from funct3[1:0]; 11 (and 110/111) is treated as a word.
    always_comb begin
        w_ex_mis = 1'b0;
        case (ex_funct3[1:0])
            2'b00:   w_ex_mis = 1'b0;
            2'b01:   w_ex_mis = ex_result[0];
            default: w_ex_mis = |ex_result[1:0];
        endcase
        w_ex_mis = w_ex_mis & w_ex_mem;
    end

    // M FSM and M register; a misaligned op is demoted to a non-writing ALU op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_m_result <= '0;
            r_m_sdata  <= '0;
            r_m_f3     <= '0;
            r_m_rd     <= '0;
            r_m_reg_we <= 1'b0;
            r_m_rr     <= 1'b0;
            r_m_st     <= 1'b0;
            r_m_mis    <= 1'b0;
        end else if (w_capture) begin
            r_state    <= (w_ex_mem && !w_ex_mis) ? S_REQ : S_ALU;
            r_m_result <= ex_result;
            r_m_sdata  <= ex_store_data;
            r_m_f3     <= ex_funct3;
            r_m_rd     <= ex_rd;
            r_m_reg_we <= ex_reg_we & ~w_ex_mis;
            r_m_rr     <= ex_mem_rr & ~w_ex_mis;
            r_m_st     <= ex_mem_we & ~w_ex_mis;
            r_m_mis    <= w_ex_mis;
        end else if (w_complete) begin
            r_state    <= S_IDLE;
            r_m_mis    <= 1'b0;
        end else if (r_state == S_REQ && dmem.dmem_gnt) begin
            r_state    <= S_WAIT;
        end
    end

    assign w_off = r_m_result[1:0];

    // Store lane steering; loads keep the full-word defaults.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_m_sdata;
        if (r_m_st) begin
            case (r_m_f3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{r_m_sdata[7:0]}};
                end
                2'b01: begin
                    w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{r_m_sdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign w_req            = (r_state == S_REQ);
    assign dmem.dmem_req    = w_req;
    assign dmem.dmem_we     = w_req & r_m_st;
    assign dmem.dmem_addr   = w_req ? r_m_result[DMEM_AW+1:2] : '0;
    assign dmem.dmem_wdata  = w_req ? w_wdata : '0;
    assign dmem.dmem_be     = w_req ? w_be : '0;

    assign w_shift = dmem.dmem_rdata >> {w_off, 3'b000};

    // Load extraction: byte lane by addr[1:0], half lane by addr[1].
    always_comb begin
        w_ld = dmem.dmem_rdata;
        case (r_m_f3)
            3'b000: w_ld = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100: w_ld = {24'h0, w_shift[7:0]};
            3'b001: w_ld = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101: w_ld = {16'h0, w_shift[15:0]};
            default: w_ld = dmem.dmem_rdata;
        endcase
    end

    // W register: loads on completion, otherwise the write port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_value <= '0;
            r_wb_rd    <= '0;
            r_wb_we    <= 1'b0;
            r_wb_rr    <= 1'b0;
        end else if (w_complete) begin
            r_wb_value <= r_m_rr ? w_ld : r_m_result;
            r_wb_rd    <= r_m_rd;
            r_wb_we    <= r_m_reg_we;
            r_wb_rr    <= r_m_rr;
        end else begin
            r_wb_we    <= 1'b0;
            r_wb_rr    <= 1'b0;
        end
    end

    assign prev_value  = r_m_result;
    assign prev_rd     = r_m_rd;
    assign prev_reg_we = w_m_valid & r_m_reg_we;
    assign prev_mem_rr = w_m_valid & r_m_rr;
    assign wb_value    = r_wb_value;
    assign wb_rd       = r_wb_rd;
    assign wb_reg_we   = r_wb_we;
    assign wb_mem_rr   = r_wb_rr;
    assign misaligned  = r_m_mis;
endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback with a delay-programmable dmem responder.
module tb_mem_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_result = '0, ex_store_data = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_we = 1'b0, ex_mem_rr = 1'b0, ex_mem_we = 1'b0;
    logic        ex_stall;
    logic [31:0] prev_value, wb_value;
    logic [4:0]  prev_rd, wb_rd;
    logic        prev_reg_we, prev_mem_rr, wb_reg_we, wb_mem_rr, misaligned;

    mem_writeback_if #(.DMEM_AW(14)) dmem_bus();

    mem_writeback #(.DMEM_AW(14)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_mem_rr(ex_mem_rr), .ex_mem_we(ex_mem_we),
        .ex_stall(ex_stall), .dmem(dmem_bus), .prev_value(prev_value),
        .prev_rd(prev_rd), .prev_reg_we(prev_reg_we), .prev_mem_rr(prev_mem_rr),
        .wb_value(wb_value), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
        .wb_mem_rr(wb_mem_rr), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] val; } wb_t;
    wb_t q[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int stall_cnt = 0, mis_cnt = 0, req_seen = 0;
    int gnt_dly = 0, rv_dly = 1, req_cnt = 0, rv_cnt = 0;
    logic pend = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [13:0] last_addr = '0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wdata = '0;
    logic        last_we = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Responder: decides gnt/rvalid shortly after each edge for the next edge.
    always @(posedge clk) begin
        #2;
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = mem_rdata;
        if (!rst_n) req_cnt = 0;
        else if (dmem_bus.dmem_req) begin
            if (req_cnt >= gnt_dly) begin
                dmem_bus.dmem_gnt = 1'b1;
                req_cnt = 0;
                if (!dmem_bus.dmem_we) begin pend = 1'b1; rv_cnt = 0; end
            end else req_cnt++;
        end else if (pend) begin
            rv_cnt++;
            if (rv_cnt >= rv_dly) begin dmem_bus.dmem_rvalid = 1'b1; pend = 1'b0; end
        end
    end

    // Monitor: scoreboard on retirements plus bus/stall bookkeeping.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ex_stall) stall_cnt++;
            if (misaligned) mis_cnt++;
            if (dmem_bus.dmem_req) begin
                req_seen++;
                last_addr  = dmem_bus.dmem_addr;
                last_be    = dmem_bus.dmem_be;
                last_wdata = dmem_bus.dmem_wdata;
                last_we    = dmem_bus.dmem_we;
            end
            if (wb_reg_we) begin
                if (q.size() == 0) chk("wb_unexpected", {27'h0, wb_rd}, 32'hFFFF_FFFF);
                else begin
                    wb_t e;
                    e = q.pop_front();
                    chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                    chk("wb_value", wb_value, e.val);
                end
            end
        end
    end

    task automatic issue(input logic rr, input logic wr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] sd, input logic rwe);
        logic mis, ok;
        wb_t e;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = res[0];
            default: mis = (res[1:0] != 2'b00);
        endcase
        mis = mis & (rr | wr);
        ex_valid = 1'b1; ex_mem_rr = rr; ex_mem_we = wr; ex_funct3 = f3;
        ex_rd = rd; ex_result = res; ex_store_data = sd; ex_reg_we = rwe;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!ex_stall) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (rwe && !mis) begin
            e.rd  = rd;
            e.val = rr ? ld_model(f3, res[1:0], mem_rdata) : res;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        logic ok;
        ex_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!ex_stall) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int a0;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
        #12;
        chk("reset_outs", {31'h0, |{ex_stall, dmem_bus.dmem_req, dmem_bus.dmem_we,
            dmem_bus.dmem_addr, dmem_bus.dmem_wdata, dmem_bus.dmem_be, prev_value,
            prev_rd, prev_reg_we, prev_mem_rr, wb_value, wb_rd, wb_reg_we,
            wb_mem_rr, misaligned}}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU stream
        stall_cnt = 0;
        issue(0, 0, 3'b000, 5'd5, 32'h11, 0, 1);
        chk("alu_prev0", prev_value, 32'h11);
        chk("alu_prev_rd", {27'h0, prev_rd}, 32'd5);
        chk("alu_prev_we", {31'h0, prev_reg_we}, 32'd1);
        a0 = acc_cyc;
        issue(0, 0, 3'b000, 5'd6, 32'h22, 0, 1);
        chk("alu_prev1", prev_value, 32'h22);
        chk("alu_no_bubble", acc_cyc - a0, 32'd1);
        idle();
        chk("alu_stall", stall_cnt, 32'd0);

        // lb with delayed grant and response
        mem_rdata = 32'h80FF_1234; gnt_dly = 2; rv_dly = 3; stall_cnt = 0;
        issue(1, 0, 3'b000, 5'd10, 32'h103, 0, 1);
        chk("lb_prev_rr", {31'h0, prev_mem_rr}, 32'd1);
        idle();
        chk("lb_stall", stall_cnt, 32'd5);
        chk("lb_addr", {18'h0, last_addr}, 32'h040);

        // halfword loads
        mem_rdata = 32'hBEEF_0000; gnt_dly = 0; rv_dly = 1;
        issue(1, 0, 3'b101, 5'd11, 32'h102, 0, 1);
        idle();
        issue(1, 0, 3'b001, 5'd12, 32'h102, 0, 1);
        idle();

        // stores
        issue(0, 1, 3'b000, 5'd0, 32'h201, 32'h1234_56AB, 0);
        idle();
        chk("sb_be", {28'h0, last_be}, 32'b0010);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_we", {31'h0, last_we}, 32'd1);
        issue(0, 1, 3'b001, 5'd0, 32'h202, 32'h1234_56AB, 0);
        idle();
        chk("sh_be", {28'h0, last_be}, 32'b1100);
        chk("sh_wdata", last_wdata, 32'h56AB_56AB);

        // misaligned lw followed immediately by an ALU op
        mis_cnt = 0; req_seen = 0;
        issue(1, 0, 3'b010, 5'd13, 32'h102, 0, 1);
        a0 = acc_cyc;
        issue(0, 0, 3'b000, 5'd7, 32'h77, 0, 1);
        chk("mis_next_accept", acc_cyc - a0, 32'd1);
        idle();
        chk("mis_pulses", mis_cnt, 32'd1);
        chk("mis_no_req", req_seen, 32'd0);

        // reset while a load waits for rvalid
        mem_rdata = 32'hDEAD_BEEF; gnt_dly = 0; rv_dly = 4;
        issue(1, 0, 3'b010, 5'd14, 32'h300, 0, 1);
        ex_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_outs", {31'h0, |{ex_stall, dmem_bus.dmem_req, dmem_bus.dmem_we,
            dmem_bus.dmem_addr, dmem_bus.dmem_wdata, dmem_bus.dmem_be, prev_value,
            prev_rd, prev_reg_we, prev_mem_rr, wb_value, wb_rd, wb_reg_we,
            wb_mem_rr, misaligned}}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_rvalid_drained", {31'h0, pend}, 32'd0);
        issue(0, 0, 3'b000, 5'd9, 32'h99, 0, 1);
        idle();

        chk("sb_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_writeback.md
# mem_writeback

Memory/writeback back end of the 5-stage RV32I pipeline. It accepts each instruction leaving the execute stage and holds it in an M register while it runs the data-memory request/grant/response handshake. It aligns load data and sign-extends it, then retires the result through a W register to the register file. It also drives the forwarding/hazard signals (prev_*, wb_*) that execute consumes, and stalls execute while a memory access is outstanding.

## Interface
- DMEM_AW, 14: data-memory word-address width; dmem_addr = ex_result[DMEM_AW+1:2].
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_result  in  32  ALU result: memory byte address for loads/stores, writeback value otherwise.
- ex_store_data  in  32  forwarded rs2 value for stores.
- ex_funct3  in  3  load/store size and signedness.
- ex_rd  in  5  destination register.
- ex_reg_we, ex_mem_rr, ex_mem_we  in  1 each  register write, load, store.
- ex_stall  out  1  M cannot accept; execute and earlier stages hold.
- dmem_req, dmem_we  out  1 each  request valid, write strobe.
- dmem_addr  out  DMEM_AW  word address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load word.
- prev_value  out  32  M result (ALU value; undefined for a load in M).
- prev_rd, prev_reg_we, prev_mem_rr  out  5/1/1  M instruction's rd, write enable, is-load.
- wb_value  out  32  W result, final (load data already aligned).
- wb_rd, wb_reg_we, wb_mem_rr  out  5/1/1  W instruction's rd, write enable, is-load. These also form the register-file write port.
- misaligned  out  1  one-cycle pulse on a misaligned access.

## Operation
- M register: captures all ex_* fields when ex_valid && !ex_stall. Otherwise it clears m_valid, except while stalling, when it holds.
- M FSM states:
  - IDLE: no valid M instruction.
  - ALU: valid, non-memory instruction.
  - REQ: dmem_req=1, waiting for dmem_gnt.
  - WAIT: load granted, waiting for dmem_rvalid.
- Transitions:
  - Capturing a memory op that is aligned enters REQ; any other capture enters ALU.
  - ALU always completes in one cycle.
  - REQ + gnt: a store completes, a load goes to WAIT.
  - WAIT + rvalid: the load completes.
  - Completing with a new capture in the same cycle re-enters ALU or REQ. Completing with no capture returns to IDLE.
- Stall: ex_stall = m_valid && !completing. An M instruction that completes this cycle accepts the next instruction in the same cycle.
- W register: on completion, loads rd, value, reg_we and mem_rr from M. Otherwise wb_reg_we=0. W never stalls.
- Data memory is never re-requested after a grant. dmem_rvalid outside WAIT is ignored. dmem_rvalid arrives no earlier than the cycle after gnt.
- Store encoding:
  - sw: be=1111, wdata=data.
  - sh: be=0011 when addr[1]=0, else 1100; wdata={2{data[15:0]}}.
  - sb: be=0001<<addr[1:0]; wdata={4{data[7:0]}}.
  - Loads drive be=1111 and dmem_we=0.
- Load extraction: select the byte or half lane by addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
  - funct3 011/110/111 is treated as lw.
- Misaligned access (lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]=1):
  - No dmem_req is issued; the instruction is treated as an ALU-state completion with reg_we forced to 0.
  - misaligned pulses in that completion cycle.
- prev_* outputs reflect M only when m_valid; otherwise prev_reg_we=0 and prev_mem_rr=0.
- Writes to rd=0 pass through unchanged. Execute and the register file ignore x0.

## Timing
- Reset (async, any state, including mid-transaction): FSM goes to IDLE, M and W are invalidated, and every output is 0. A pending grant or response is abandoned. After reset, rvalid is ignored until a new load reaches WAIT.
- ALU op: captured at edge n, visible on prev_* during cycle n, visible on wb_* during cycle n+1 for exactly one cycle.
- Store with gnt in the first REQ cycle: ex_stall=0, one-cycle M occupancy, W in the next cycle with wb_reg_we=0.
- Load: REQ cycles k≥1 until gnt, then WAIT cycles j≥1 until rvalid. ex_stall=1 for every cycle except the one where rvalid is sampled. wb_value is valid the cycle after rvalid.
- Back-to-back ALU ops: one per cycle, no bubbles.

## Test plan
- ALU stream: x5←0x11, x6←0x22 on consecutive cycles → prev_value 0x11 then 0x22, wb_value one cycle later each, ex_stall never asserted.
- lb from addr 0x103 with rdata=0x80FF_1234, gnt delayed 2 cycles, rvalid 3 cycles after gnt → wb_value=0xFFFF_FF80, ex_stall high for 5 cycles, dmem_addr=0x040.
- lhu addr 0x102, rdata=0xBEEF_0000 → wb_value=0x0000_BEEF; lh same → 0xFFFF_BEEF.
- sb data 0x1234_56AB to addr 0x201 → dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_we=1, wb_reg_we=0. sh to 0x202 → be=1100, wdata=0x56AB_56AB.
- lw to 0x102 → misaligned pulses once, dmem_req stays 0, wb_reg_we=0, next instruction accepted the following cycle.
- Assert rst_n low during WAIT, then deliver rvalid → all outputs are 0 immediately, rvalid is ignored, and the next ALU op retires normally.
